axi_slave: RTL and testbench



---
 rtl/axi_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi_slave.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave.sv
// AXI4-Lite responder bridging one outstanding AXI transaction onto a
// simple req/ack register bus. Decodes a single address window and returns
// OKAY, SLVERR (back-end error or timeout) or DECERR (outside the window).
module axi_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ack_i,
  input  logic        reg_err_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_RESP,
    WR_ACC,
    WR_RESP
  } state_t;

  state_t      state;
  logic        aw_got;
  logic        w_got;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [31:0] cnt;
  logic        wr_busy;
  logic        timeout_hit;

  // Wrap-safe window check: the offset from the base is compared unsigned,
  // so addresses below BASE_ADDR wrap to huge offsets and fall outside.
  function automatic logic in_window(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off < ADDR_SPAN;
  endfunction

  assign wr_busy     = (state == WR_ACC) || (state == WR_RESP);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TIMEOUT - 32'd1);

  // Readies are held low while reset is asserted so nothing handshakes then.
  assign awready_o = !rst_i && !aw_got && !wr_busy;
  assign wready_o  = !rst_i && !w_got && !wr_busy;
  assign arready_o = !rst_i && (state == IDLE) && !(aw_got && w_got);

  // Capture AW and W independently; initiators may complete them in
  // different cycles, and the flags only clear once the B response is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
    end else if (state == WR_RESP && bready_i) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (awvalid_i && awready_o) begin
        aw_addr <= awaddr_i;
        aw_got  <= 1'b1;
      end
      if (wvalid_i && wready_o) begin
        w_data <= wdata_i;
        w_got  <= 1'b1;
      end
    end
  end

  // Transaction FSM with registered AXI response and back-end request outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      rresp_o     <= RESP_OKAY;
      bvalid_o    <= 1'b0;
      bresp_o     <= RESP_OKAY;
      reg_req_o   <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_got && w_got) begin
            // A fully captured write wins over a new read address.
            if (in_window(aw_addr)) begin
              state       <= WR_ACC;
              reg_req_o   <= 1'b1;
              reg_we_o    <= 1'b1;
              reg_addr_o  <= aw_addr;
              reg_wdata_o <= w_data;
              cnt         <= '0;
            end else begin
              state    <= WR_RESP;
              bvalid_o <= 1'b1;
              bresp_o  <= RESP_DECERR;
            end
          end else if (arvalid_i) begin
            if (in_window(araddr_i)) begin
              state      <= RD_ACC;
              reg_req_o  <= 1'b1;
              reg_we_o   <= 1'b0;
              reg_addr_o <= araddr_i;
              cnt        <= '0;
            end else begin
              state    <= RD_RESP;
              rvalid_o <= 1'b1;
              rdata_o  <= '0;
              rresp_o  <= RESP_DECERR;
            end
          end
        end
        RD_ACC: begin
          if (reg_ack_i) begin
            state     <= RD_RESP;
            reg_req_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= reg_rdata_i;
            rresp_o   <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
          end else if (timeout_hit) begin
            state     <= RD_RESP;
            reg_req_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= '0;
            rresp_o   <= RESP_SLVERR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RD_RESP: begin
          if (rready_i) begin
            state    <= IDLE;
            rvalid_o <= 1'b0;
          end
        end
        WR_ACC: begin
          if (reg_ack_i) begin
            state     <= WR_RESP;
            reg_req_o <= 1'b0;
            bvalid_o  <= 1'b1;
            bresp_o   <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
          end else if (timeout_hit) begin
            state     <= WR_RESP;
            reg_req_o <= 1'b0;
            bvalid_o  <= 1'b1;
            bresp_o   <= RESP_SLVERR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            state    <= IDLE;
            bvalid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: a transaction-level reference model tracks
// what every output must be each cycle, a bench-side register responder
// logs back-end accesses, and directed scenarios pin key values literally.
module tb_axi_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic        clk;
  logic        rst_i;
  logic        arvalid_i, arready_o;
  logic [31:0] araddr_i;
  logic        rvalid_o, rready_i;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        awvalid_i, awready_o;
  logic [31:0] awaddr_i;
  logic        wvalid_i, wready_o;
  logic [31:0] wdata_i;
  logic        bvalid_o, bready_i;
  logic [1:0]  bresp_o;
  logic        reg_req_o, reg_we_o;
  logic [31:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic        reg_ack_i, reg_err_i;

  axi_slave #(.BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
    .reg_ack_i(reg_ack_i), .reg_err_i(reg_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- back-end register responder ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } be_t;

  be_t         be_q[$];
  logic [31:0] mem[logic [31:0]];
  int          be_delay = 1;   // req cycles until ack (ack on the Nth); 0 = never
  logic        be_err = 1'b0;
  int          rk = 0;
  be_t         rcur;

  initial begin
    reg_ack_i   = 1'b0;
    reg_err_i   = 1'b0;
    reg_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reg_req_o) begin
        if (rk == 0) begin
          rcur.we    = reg_we_o;
          rcur.addr  = reg_addr_o;
          rcur.wdata = reg_wdata_o;
        end
        rk++;
        reg_rdata_i = mem.exists(reg_addr_o) ? mem[reg_addr_o] : 32'h0;
        reg_ack_i   = (be_delay != 0) && (rk == be_delay);
        reg_err_i   = be_err;
        if (reg_ack_i && reg_we_o) mem[reg_addr_o] = reg_wdata_o;
      end else begin
        reg_ack_i   = 1'b0;
        reg_err_i   = 1'b0;
        reg_rdata_i = '0;
        if (rk != 0) begin
          rcur.len = rk;
          be_q.push_back(rcur);
          rk = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit          busy, aw_got, w_got;
  logic [31:0] aw_a, w_d;
  int          m_cnt;
  logic        m_rvalid, m_bvalid, m_req, m_we;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [1:0]  m_rresp, m_bresp;

  function automatic bit in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SPAN}));
  endfunction

  task automatic model_reset();
    busy = 0; aw_got = 0; w_got = 0; aw_a = '0; w_d = '0; m_cnt = 0;
    m_rvalid = 0; m_bvalid = 0; m_req = 0; m_we = 0;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
  endtask

  task automatic model_finish(input logic [1:0] resp, input logic [31:0] data);
    m_req = 0;
    if (m_we) begin
      m_bvalid = 1; m_bresp = resp;
    end else begin
      m_rvalid = 1; m_rresp = resp; m_rdata = data;
    end
  endtask

  initial model_reset();

  // Compare process: outputs against the model, then advance the model
  // with the inputs that the coming clock edge will see.
  always @(negedge clk) begin
    if (rst_i) begin
      chk("reset ctl", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o,
                        reg_req_o, reg_we_o, rresp_o, bresp_o}, '0);
      chk("reset rdata", rdata_o, '0);
      chk("reset reg bus", {reg_addr_o, reg_wdata_o}, '0);
      model_reset();
    end else begin
      bit m_ar, ar_hs, aw_hs, w_hs;
      m_ar = !busy && !(aw_got && w_got);
      chk("ready", {arready_o, awready_o, wready_o}, {m_ar, !aw_got, !w_got});
      chk("rvalid", rvalid_o, m_rvalid);
      chk("rdata", rdata_o, m_rdata);
      chk("rresp", rresp_o, m_rresp);
      chk("bvalid", bvalid_o, m_bvalid);
      chk("bresp", bresp_o, m_bresp);
      chk("reg_req", reg_req_o, m_req);
      if (m_req) begin
        chk("reg_we", reg_we_o, m_we);
        chk("reg_addr", reg_addr_o, m_addr);
        if (m_we) chk("reg_wdata", reg_wdata_o, m_wdata);
      end

      ar_hs = arvalid_i && m_ar;
      aw_hs = awvalid_i && !aw_got;
      w_hs  = wvalid_i && !w_got;
      if (m_req) begin
        m_cnt++;
        if (reg_ack_i) model_finish(reg_err_i ? 2'b10 : 2'b00, reg_rdata_i);
        else if (TMO != 0 && m_cnt == TMO) model_finish(2'b10, 32'h0);
      end else if (m_rvalid && rready_i) begin
        m_rvalid = 0; busy = 0;
      end else if (m_bvalid && bready_i) begin
        m_bvalid = 0; busy = 0; aw_got = 0; w_got = 0;
      end else if (!busy && aw_got && w_got) begin
        busy = 1; m_we = 1;
        if (in_win(aw_a)) begin
          m_req = 1; m_addr = aw_a; m_wdata = w_d; m_cnt = 0;
        end else begin
          m_bvalid = 1; m_bresp = 2'b11;
        end
      end else if (ar_hs) begin
        busy = 1; m_we = 0;
        if (in_win(araddr_i)) begin
          m_req = 1; m_addr = araddr_i; m_cnt = 0;
        end else begin
          m_rvalid = 1; m_rdata = 32'h0; m_rresp = 2'b11;
        end
      end
      if (aw_hs) begin aw_got = 1; aw_a = awaddr_i; end
      if (w_hs)  begin w_got = 1;  w_d = wdata_i;  end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_ar(input logic [31:0] a);
    bit done;
    done = 0;
    arvalid_i = 1; araddr_i = a;
    for (int n = 0; n < 100; n++) begin
      if (arready_o) done = 1;
      tick();
      if (done) break;
    end
    arvalid_i = 0;
    chk("ar handshake", done, 1);
  endtask

  task automatic do_aw(input logic [31:0] a);
    bit done;
    done = 0;
    awvalid_i = 1; awaddr_i = a;
    for (int n = 0; n < 100; n++) begin
      if (awready_o) done = 1;
      tick();
      if (done) break;
    end
    awvalid_i = 0;
    chk("aw handshake", done, 1);
  endtask

  task automatic do_w(input logic [31:0] d);
    bit done;
    done = 0;
    wvalid_i = 1; wdata_i = d;
    for (int n = 0; n < 100; n++) begin
      if (wready_o) done = 1;
      tick();
      if (done) break;
    end
    wvalid_i = 0;
    chk("w handshake", done, 1);
  endtask

  task automatic get_r(output logic [31:0] d, output logic [1:0] r);
    bit got;
    got = 0; d = '0; r = '0;
    rready_i = 1;
    for (int n = 0; n < 100; n++) begin
      if (rvalid_o) begin d = rdata_o; r = rresp_o; got = 1; end
      tick();
      if (got) break;
    end
    rready_i = 0;
    chk("r response seen", got, 1);
  endtask

  task automatic get_b(output logic [1:0] r);
    bit got;
    got = 0; r = '0;
    bready_i = 1;
    for (int n = 0; n < 100; n++) begin
      if (bvalid_o) begin r = bresp_o; got = 1; end
      tick();
      if (got) break;
    end
    bready_i = 0;
    chk("b response seen", got, 1);
  endtask

  task automatic pop_be(output be_t e);
    chk("be record present", be_q.size() != 0, 1);
    if (be_q.size() != 0) e = be_q.pop_front();
    else begin e.we = 0; e.addr = '0; e.wdata = '0; e.len = 0; end
  endtask

  task automatic settle(input int want);
    for (int n = 0; n < 200; n++) begin
      if (be_q.size() >= want && !rvalid_o && !bvalid_o && !reg_req_o) break;
      tick();
    end
    chk("be access count", be_q.size(), want);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    be_t         e;
    rst_i = 1;
    arvalid_i = 0; araddr_i = '0; rready_i = 0;
    awvalid_i = 0; awaddr_i = '0; wvalid_i = 0; wdata_i = '0; bready_i = 0;
    tick(); tick();
    chk("reset state", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o, reg_req_o}, '0);
    tick();
    rst_i = 0;
    tick();

    // Read with ack on the third request cycle
    mem[32'h10] = 32'hDEADBEEF;
    be_delay = 3; be_err = 0;
    do_ar(32'h10);
    get_r(d, r);
    chk("t1 rdata", d, 32'hDEADBEEF);
    chk("t1 rresp", r, 2'b00);
    pop_be(e);
    chk("t1 req cycles", e.len, 3);
    chk("t1 access", {e.we, e.addr}, {1'b0, 32'h10});

    // Write: W two cycles before AW, B stalled by bready low for 4 cycles
    be_delay = 2;
    do_w(32'h12345678);
    tick(); tick();
    do_aw(32'h20);
    bready_i = 0;
    for (int n = 0; n < 50; n++) begin
      if (bvalid_o) break;
      tick();
    end
    chk("t2 bvalid seen", bvalid_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2 bvalid held", {bvalid_o, bresp_o}, {1'b1, 2'b00});
    end
    bready_i = 1;
    tick();
    bready_i = 0;
    chk("t2 bvalid dropped", bvalid_o, 0);
    pop_be(e);
    chk("t2 access", {e.we, e.addr, e.wdata}, {1'b1, 32'h20, 32'h12345678});
    chk("t2 single access", be_q.size(), 0);

    // Out-of-window read and write
    do_ar(32'h2000);
    get_r(d, r);
    chk("t3 read decerr", {d, r}, {32'h0, 2'b11});
    do_w(32'hABCD0000);
    do_aw(32'h1000);
    get_b(r);
    chk("t3 write decerr", r, 2'b11);
    chk("t3 no back-end access", be_q.size(), 0);

    // Back-end error, then timeout
    mem[32'h40] = 32'hCAFE0040;
    be_delay = 1; be_err = 1;
    do_ar(32'h40);
    get_r(d, r);
    chk("t4 slverr", {d, r}, {32'hCAFE0040, 2'b10});
    be_err = 0;
    pop_be(e);
    chk("t4 err req cycles", e.len, 1);
    be_delay = 0;
    do_ar(32'h44);
    get_r(d, r);
    chk("t4 timeout resp", {d, r}, {32'h0, 2'b10});
    pop_be(e);
    chk("t4 timeout req cycles", e.len, TMO);

    // Contention: AR, AW and W in the same idle cycle
    be_delay = 2;
    rready_i = 1; bready_i = 1;
    fork
      do_ar(32'h80);
      do_aw(32'h84);
      do_w(32'h000055AA);
    join
    settle(2);
    pop_be(e);
    chk("t5 first is read", {e.we, e.addr}, {1'b0, 32'h80});
    pop_be(e);
    chk("t5 then write", {e.we, e.addr, e.wdata}, {1'b1, 32'h84, 32'h000055AA});

    // Captured write served before a newly presented AR
    be_delay = 3;
    do_ar(32'h90);
    fork
      do_aw(32'h94);
      do_w(32'h00000077);
    join
    do_ar(32'hA0);
    settle(3);
    pop_be(e);
    chk("t5b read 0x90", {e.we, e.addr}, {1'b0, 32'h90});
    pop_be(e);
    chk("t5b write 0x94", {e.we, e.addr, e.wdata}, {1'b1, 32'h94, 32'h77});
    pop_be(e);
    chk("t5b read 0xA0", {e.we, e.addr}, {1'b0, 32'hA0});
    rready_i = 0; bready_i = 0;

    // Asynchronous reset in the middle of a write access
    be_delay = 0;
    fork
      do_aw(32'h100);
      do_w(32'h00000099);
    join
    tick();
    chk("t6 in write access", {reg_req_o, reg_we_o}, 2'b11);
    #3;
    rst_i = 1;
    #1;
    chk("t6 async ctl zero", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o,
                              reg_req_o, reg_we_o, rresp_o, bresp_o}, '0);
    chk("t6 async data zero", {rdata_o, reg_addr_o, reg_wdata_o}, '0);
    tick(); tick();
    rst_i = 0;
    tick();
    be_q.delete();
    be_delay = 1;
    do_ar(32'h10);
    get_r(d, r);
    chk("t6 read after reset", {d, r}, {32'hDEADBEEF, 2'b00});
    pop_be(e);
    chk("t6 access", {e.we, e.addr, 32'(e.len)}, {1'b0, 32'h10, 32'd1});

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
